// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32 fetch stage; latches the PC, runs an imem req/ack read and captures the IR.
// Optional FETCH_TIMEOUT_EN aborts a fetch after TIMEOUT_CYCLES REQ cycles without imem_ack.
module instr_fetch_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [31:0] pc_cur,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
    state_t state, state_nxt;
    logic accept, timeout;
    assign accept = (state == IDLE) && fetch_start;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || state != REQ) cnt <= '0;
        else if (!imem_ack) cnt <= cnt + 1'b1;
    end
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    // REQ waits indefinitely; the limit only matters with the timeout built in
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_start) state_nxt = (pc_cur[1:0] != 2'b00) ? ERR : REQ;
            REQ:     state_nxt = imem_ack ? DONE : (timeout ? ERR : REQ);
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        imem_req  = (state == REQ);
        ir_valid  = (state == DONE);
        fetch_err = (state == ERR);
        busy      = (state != IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_addr <= '0;
            pc_plus4  <= '0;
            ir        <= 32'h0000_0013;
        end else begin
            if (accept) begin
                imem_addr <= pc_cur;
                pc_plus4  <= pc_cur + 32'd4;
            end
            if (state == REQ && imem_ack) ir <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table, hand sequences and random fetches against a transaction-level model.
module tb_instr_fetch_unit;
    localparam int TO = 16;
    logic        clk = 1'b0;
    logic        rst, fetch_start, imem_ack;
    logic [31:0] pc_cur, imem_rdata;
    logic        imem_req, ir_valid, busy, fetch_err;
    logic [31:0] imem_addr, ir, pc_plus4;
    int n_cmp = 0;
    int n_bad = 0;
    int obs_err, obs_valid, obs_req, obs_lat, obs_addr_ok, obs_extra_req, obs_hung;
    logic [31:0] model_ir;

    instr_fetch_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_cur(pc_cur),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid),
        .pc_plus4(pc_plus4), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          delay;
        bit          mid;
        bit          err;
        logic [31:0] ir;
        logic [31:0] p4;
    } vec_t;
    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // one fetch: pulse start, answer the request after `delay` REQ cycles, throw stale acks outside REQ
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] rdata, input int delay, input bit mid);
        int idx;
        obs_err = 0; obs_valid = 0; obs_req = 0; obs_lat = 0;
        obs_addr_ok = 1; obs_extra_req = 0;
        pc_cur = pc;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        pc_cur = $urandom;
        idx = 1;
        while (busy && idx < 64) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            if (imem_req) begin
                if (imem_addr !== pc) obs_addr_ok = 0;
                if (obs_req == delay) begin
                    imem_ack = 1'b1;
                    imem_rdata = rdata;
                end
                if (mid && obs_req == 0) begin
                    fetch_start = 1'b1;
                    pc_cur = pc ^ 32'h40;
                end
                obs_req++;
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (ir_valid) begin obs_valid++; obs_lat = idx; end
            if (fetch_err) begin obs_err++; obs_lat = idx; end
            tick();
            fetch_start = 1'b0;
            idx++;
        end
        obs_hung = busy ? 1 : 0;
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        repeat (2) begin
            if (imem_req) obs_extra_req++;
            tick();
        end
        imem_ack = 1'b0;
    endtask

    task automatic check_fetch(input string name, input logic [31:0] pc, input int delay,
                               input bit err, input logic [31:0] exp_ir, input logic [31:0] exp_p4);
        chk({name, ".hung"}, obs_hung, 0);
        chk({name, ".err"}, obs_err, err ? 1 : 0);
        chk({name, ".valid"}, obs_valid, err ? 0 : 1);
        chk({name, ".reqcyc"}, obs_req, err ? 0 : delay + 1);
        chk({name, ".lat"}, obs_lat, err ? 1 : delay + 2);
        chk({name, ".addr_stable"}, obs_addr_ok, 1);
        chk({name, ".extra_req"}, obs_extra_req, 0);
        chk({name, ".ir"}, ir, exp_ir);
        chk({name, ".pc_plus4"}, pc_plus4, exp_p4);
        chk({name, ".imem_addr"}, imem_addr, pc);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, ".req"}, imem_req, 0);
        chk({name, ".addr"}, imem_addr, 0);
        chk({name, ".ir"}, ir, 32'h0000_0013);
        chk({name, ".ir_valid"}, ir_valid, 0);
        chk({name, ".pc_plus4"}, pc_plus4, 0);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".fetch_err"}, fetch_err, 0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h00A0_0093, 0, 1'b0, 1'b0, 32'h00A0_0093, 32'h0000_0104};
        vecs[1] = '{32'h0000_0200, 32'h1234_5678, 3, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0204};
        vecs[2] = '{32'h0000_0102, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0106};
        vecs[3] = '{32'hFFFF_FFFC, 32'hCAFE_F00D, 1, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[4] = '{32'h0000_0003, 32'h5555_AAAA, 2, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_0007};
        vecs[5] = '{32'h8000_0001, 32'h0BAD_0BAD, 0, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h8000_0005};

        rst = 1'b1; fetch_start = 1'b1; pc_cur = 32'h100; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk_reset_vals("reset_hold");
        rst = 1'b0; fetch_start = 1'b0; imem_ack = 1'b0;
        tick();
        chk_reset_vals("reset_release");

        for (int i = 0; i < 6; i++) begin
            do_fetch(vecs[i].pc, vecs[i].rdata, vecs[i].delay, vecs[i].mid);
            check_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].delay, vecs[i].err, vecs[i].ir, vecs[i].p4);
        end

        pc_cur = 32'h400; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        chk("midreq.req_before_rst", imem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("midreq_rst");
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
        tick();
        tick();
        chk("stale_ack.ir", ir, 32'h0000_0013);
        chk("stale_ack.busy", busy, 0);
        chk("stale_ack.ir_valid", ir_valid, 0);
        imem_ack = 1'b0;
        model_ir = 32'h0000_0013;

`ifdef FETCH_TIMEOUT_EN
        do_fetch(32'h500, 32'h1111_2222, 1000, 1'b0);
        chk("timeout.hung", obs_hung, 0);
        chk("timeout.err", obs_err, 1);
        chk("timeout.valid", obs_valid, 0);
        chk("timeout.reqcyc", obs_req, TO);
        chk("timeout.lat", obs_lat, TO + 1);
        chk("timeout.ir", ir, model_ir);
`else
        do_fetch(32'h500, 32'h1111_2222, 20, 1'b0);
        model_ir = 32'h1111_2222;
        check_fetch("longwait", 32'h500, 20, 1'b0, model_ir, 32'h504);
`endif

        for (int i = 0; i < 30; i++) begin
            logic [31:0] pc, rd;
            int d;
            bit m, mis;
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            rd = $urandom;
            d = $urandom_range(0, 4);
            m = 1'($urandom_range(0, 1));
            mis = (pc % 4) != 0;
            if (!mis) model_ir = rd;
            do_fetch(pc, rd, d, m);
            check_fetch($sformatf("rnd%0d", i), pc, d, mis, model_ir, pc + 32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the multicycle microprogrammed RV32 core. It sits directly downstream of the program counter register. On a pulse from the microsequencer, it latches the current PC and runs a request/acknowledge read on instruction memory. It then captures the returned word into the instruction register and presents the sequential next PC (PC+4), which the datapath feeds back as the PC register input.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 16: maximum cycles in REQ without `imem_ack` before a fetch error; only used when the timeout feature is compiled in.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_start  in  1  one-cycle pulse from the microsequencer requesting a fetch; ignored unless state is IDLE.
- pc_cur  in  32  current PC from the PC register output; sampled only on an accepted `fetch_start`.
- imem_req  out  1  read request to instruction memory; high throughout REQ.
- imem_addr  out  32  fetch address; registered, stable while `imem_req` is high.
- imem_ack  in  1  memory acknowledge; qualifies `imem_rdata` in the same cycle.
- imem_rdata  in  32  instruction word from memory.
- ir  out  32  instruction register; holds the last successfully fetched word.
- ir_valid  out  1  one-cycle pulse: `ir` was updated this fetch.
- pc_plus4  out  32  registered `imem_addr + 4`, modulo 2^32.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  one-cycle pulse on a misaligned PC, or on timeout when that feature is compiled in.

## Operation
- States: IDLE, REQ, DONE, ERR. Encoding is free. Only `rst` returns the block to IDLE asynchronously to the FSM flow.
- IDLE with `fetch_start`=1:
  - Register `imem_addr <= pc_cur` and `pc_plus4 <= pc_cur + 4`.
  - If `pc_cur[1:0] != 0`, go to ERR; otherwise go to REQ.
- IDLE with `fetch_start`=0: stay in IDLE.
- REQ:
  - `imem_req`=1 and `imem_addr` is held.
  - On `imem_ack`=1, capture `ir <= imem_rdata` and go to DONE.
  - Otherwise stay in REQ.
- DONE: `ir_valid`=1 for this single cycle, then go to IDLE.
- ERR: `fetch_err`=1 for this single cycle, `ir` is unchanged, no request is issued, then go to IDLE.
- `fetch_start` asserted while `busy`=1 is dropped. It is neither queued nor errored.
- `imem_ack` outside REQ is ignored, including a stale ack arriving after reset.
- Adder: 32-bit unsigned with carry discarded, so 0xFFFF_FFFC gives 0x0000_0000.
- `pc_plus4` and `imem_addr` hold their values until the next accepted `fetch_start`.

## Timing
- Reset values:
  - State IDLE.
  - `imem_req`=0, `imem_addr`=0, `ir`=0x0000_0013 (NOP).
  - `ir_valid`=0, `pc_plus4`=0, `busy`=0, `fetch_err`=0.
- `fetch_start` sampled at edge N: `imem_req` is high from cycle N+1.
- `imem_ack` sampled at edge M: `ir` and `ir_valid` are visible in cycle M+1, and `imem_req` is low in cycle M+1.
- Minimum latency, with ack in the first REQ cycle: `fetch_start` to `ir_valid` is 2 cycles. Back-to-back fetches can start every 3 cycles.
- Misaligned PC: `fetch_err` is high in cycle N+1 and `imem_req` never rises.
- `rst` high in any state, including mid-REQ: all outputs take their reset values in the next cycle and any outstanding request is abandoned.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each REQ cycle without an ack.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to ERR instead: `imem_req` drops and `fetch_err` pulses the next cycle.
  - An ack in the same cycle as the limit wins and is treated as a normal capture.
- FETCH_TIMEOUT_EN undefined: no counter exists and REQ waits indefinitely for `imem_ack`.

## Test plan
- Reset: hold `rst` 2 cycles, then release -> `ir`=0x0000_0013 and every other output is 0; `fetch_start` is ignored during reset.
- Basic fetch: `pc_cur`=0x0000_0100, pulse `fetch_start`, ack in the first REQ cycle with `imem_rdata`=0x00A0_0093 -> `imem_addr`=0x100, `ir`=0x00A0_0093, `ir_valid` 2 cycles after start, `pc_plus4`=0x104.
- Wait states and ignored start: delay ack 3 cycles and pulse `fetch_start` mid-REQ -> `imem_addr` stays stable, exactly one `ir_valid`, and no second request.
- Misaligned: `pc_cur`=0x0000_0102 -> `fetch_err` pulses 1 cycle after start, `imem_req` stays 0, and `ir` is unchanged.
- Wrap: `pc_cur`=0xFFFF_FFFC -> `pc_plus4`=0x0000_0000.
- Reset mid-REQ, then a stale ack (and, with FETCH_TIMEOUT_EN defined, no ack for 16 cycles) -> the stale ack is ignored; on timeout `fetch_err` pulses once and `imem_req` drops.
